// File: rtl/network_input_descriptor_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | network_input_descriptor_arbiter_pkg: shared widths, FSM codes, layout   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package network_input_descriptor_arbiter_pkg;

  localparam logic [0:0] OUT_IDLE = 1'b0;
  localparam logic [0:0] OUT_WAIT = 1'b1;

  // FIFO entry layout, MSB first: {class, inport, descriptor}
  localparam int ENTRY_DESC_LSB = 0;

  function automatic int port_iw(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int entry_inport_lsb(input int dw);
    return ENTRY_DESC_LSB + dw;
  endfunction

  function automatic int entry_class_bit(input int dw, input int iw);
    return ENTRY_DESC_LSB + dw + iw;
  endfunction

  function automatic int entry_width(input int dw, input int iw);
    return dw + iw + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/network_input_descriptor_arbiter_fifo.sv
// +--------------------------------------------------------------------------+
// | desc_sync_fifo: show-ahead synchronous FIFO with occupancy count         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module desc_sync_fifo #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (usedw == UW'(DEPTH));
  assign empty   = (usedw == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   usedw <= usedw + UW'(1);
        2'b01:   usedw <= usedw - UW'(1);
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/network_input_descriptor_arbiter.sv
// +--------------------------------------------------------------------------+
// | network_input_descriptor_arbiter: round-robin N-port descriptor merger   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module network_input_descriptor_arbiter
  import network_input_descriptor_arbiter_pkg::*;
#(
  parameter int  PORT_NUM   = 4,
  parameter int  DESC_WIDTH = 57,
  parameter int  FIFO_DEPTH = 8,
  localparam int PORT_IW    = port_iw(PORT_NUM),
  localparam int USEDW_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic [PORT_NUM-1:0]              port_type,
  input  logic [PORT_NUM-1:0]              iv_descriptor_wr,
  input  logic [PORT_NUM*DESC_WIDTH-1:0]   iv_descriptor,
  output logic [PORT_NUM-1:0]              ov_descriptor_ack,
  output logic                             o_descriptor_wr_to_host,
  output logic                             o_descriptor_wr_to_network,
  output logic [DESC_WIDTH-1:0]            ov_descriptor,
  output logic [PORT_IW-1:0]               ov_descriptor_inport,
  input  logic                             i_descriptor_ack,
  output logic [PORT_NUM-1:0]              ov_desc_accept_pulse,
  output logic [USEDW_W-1:0]               ov_fifo_usedw,
  output logic                             ov_output_state
);

  localparam int ENTRY_W    = entry_width(DESC_WIDTH, PORT_IW);
  localparam int INPORT_LSB = entry_inport_lsb(DESC_WIDTH);
  localparam int CLASS_BIT  = entry_class_bit(DESC_WIDTH, PORT_IW);

  logic [PORT_IW-1:0]    last_grant;
  logic [PORT_NUM-1:0]   eligible;
  logic [PORT_NUM-1:0]   grant_onehot;
  logic                  grant_valid;
  logic [PORT_IW-1:0]    grant_idx;
  logic [PORT_IW-1:0]    cand_idx;
  int                    cand;
  logic [DESC_WIDTH-1:0] sel_desc;
  logic                  sel_class;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [0:0]            out_state;

  // A port acked last cycle is masked so its one-cycle wr drop is not re-granted
  assign eligible = iv_descriptor_wr & ~ov_descriptor_ack;

  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    cand         = 0;
    cand_idx     = '0;
    if (!fifo_full) begin
      for (int k = 1; k <= PORT_NUM; k++) begin
        cand     = (int'(last_grant) + k) % PORT_NUM;
        cand_idx = PORT_IW'(cand);
        if (!grant_valid && eligible[cand_idx]) begin
          grant_valid            = 1'b1;
          grant_idx              = cand_idx;
          grant_onehot[cand_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_desc = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (grant_onehot[i]) begin
        sel_desc = iv_descriptor[i*DESC_WIDTH +: DESC_WIDTH];
      end
    end
  end

  // Class is frozen into the entry at accept time
  assign sel_class  = |(port_type & grant_onehot);
  assign push_entry = {sel_class, grant_idx, sel_desc};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      last_grant           <= PORT_IW'(PORT_NUM - 1);
      ov_descriptor_ack    <= '0;
      ov_desc_accept_pulse <= '0;
    end else begin
      ov_descriptor_ack    <= grant_onehot;
      ov_desc_accept_pulse <= grant_onehot;
      if (grant_valid) begin
        last_grant <= grant_idx;
      end
    end
  end

  desc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .push    (grant_valid),
    .wr_data (push_entry),
    .pop     (fifo_pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .usedw   (ov_fifo_usedw)
  );

  assign fifo_pop        = (out_state == OUT_IDLE) && !fifo_empty;
  assign ov_output_state = out_state;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_state                  <= OUT_IDLE;
      o_descriptor_wr_to_host    <= 1'b0;
      o_descriptor_wr_to_network <= 1'b0;
      ov_descriptor              <= '0;
      ov_descriptor_inport       <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (!fifo_empty) begin
            ov_descriptor              <= head_entry[ENTRY_DESC_LSB +: DESC_WIDTH];
            ov_descriptor_inport       <= head_entry[INPORT_LSB +: PORT_IW];
            o_descriptor_wr_to_host    <= head_entry[CLASS_BIT];
            o_descriptor_wr_to_network <= ~head_entry[CLASS_BIT];
            out_state                  <= OUT_WAIT;
          end
        end
        OUT_WAIT: begin
          if (i_descriptor_ack) begin
            o_descriptor_wr_to_host    <= 1'b0;
            o_descriptor_wr_to_network <= 1'b0;
            out_state                  <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/network_input_descriptor_arbiter.md
# network_input_descriptor_arbiter

Parametrised N-port descriptor merger behind the per-port network input process instances. Each port hands over a descriptor through a wr/ack handshake. The block picks one port per cycle by round-robin, tags the descriptor with its input port and destination class, and buffers it in a FIFO. It then presents one descriptor at a time to the downstream lookup, routed to either the host or the network strobe. It replaces the fixed two-port descriptor wiring and the ORed acknowledge with a scalable, fair, buffered path.

## Interface
- PORT_NUM, 4: number of input ports (2..16)
- DESC_WIDTH, 57: descriptor width
- FIFO_DEPTH, 8: descriptor FIFO depth (power of two, ≥2)
- PORT_IW, derived: max(1, clog2(PORT_NUM))

- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- port_type  in  PORT_NUM  per port: 1 = terminal (to host), 0 = network (to network)
- iv_descriptor_wr  in  PORT_NUM  per-port descriptor valid, held until acked
- iv_descriptor  in  PORT_NUM*DESC_WIDTH  port i occupies bits [i*DESC_WIDTH +: DESC_WIDTH]
- ov_descriptor_ack  out  PORT_NUM  one-cycle acceptance pulse per port
- o_descriptor_wr_to_host  out  1  output valid, host class
- o_descriptor_wr_to_network  out  1  output valid, network class
- ov_descriptor  out  DESC_WIDTH  output descriptor
- ov_descriptor_inport  out  PORT_IW  originating port
- i_descriptor_ack  in  1  downstream acceptance pulse
- ov_desc_accept_pulse  out  PORT_NUM  one-cycle statistics pulse per accepted descriptor
- ov_fifo_usedw  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- ov_output_state  out  1  output FSM state (debug)

## Operation
- **Input arbitration**
  - Eligible ports: wr=1, and the port was not acked in the previous cycle. This mask absorbs the source's one-cycle wr drop.
  - A grant is given only when the FIFO is not full. A same-cycle pop is not credited.
  - Round-robin search starts at last_grant+1 mod PORT_NUM. last_grant resets to PORT_NUM-1, so port 0 has first priority.
  - Grant effects at the clock edge:
    - ov_descriptor_ack[g]=1 for one cycle;
    - ov_desc_accept_pulse[g]=1;
    - FIFO write of {port_type[g], g, descriptor[g]};
    - last_grant=g.
  - port_type is sampled at accept. Later changes do not affect queued entries.
- **Output FSM**
  - OUT_IDLE(0): if the FIFO is not empty, pop, register the descriptor, inport and class, and assert the class strobe → OUT_WAIT(1).
  - OUT_WAIT(1): hold the strobe and data stable until i_descriptor_ack=1. Then clear the strobe at that edge → OUT_IDLE.
  - The two strobes are never high together.
  - A pop may coincide with a push. The FIFO count is unchanged in that case.
- i_descriptor_ack while in OUT_IDLE is ignored.
- **Reset** (asynchronous, any time): all outputs 0, FIFO emptied, FSM to OUT_IDLE, mask cleared. Descriptors in flight are dropped. A source must re-present after reset.

## Timing
- Input wr high at cycle 0, FIFO empty, FSM idle:
  - ack and accept pulse high in cycle 1;
  - output strobe high in cycle 2.
- Minimum output gap: downstream ack in cycle k → strobe low in cycle k+1 → next strobe high no earlier than cycle k+2.
- Per-port throughput: at most one accept every 2 cycles. Aggregate: one accept per cycle.
- Full FIFO: no acks issued. Sources stall with wr held and data stable. Nothing is dropped inside the block.
- ov_fifo_usedw is registered and valid the cycle after a push or pop.

## Structure
- Shared package holds:
  - PORT_IW computation;
  - output state encodings OUT_IDLE/OUT_WAIT;
  - FIFO entry layout offsets (class bit MSB, then inport, then descriptor).
- One sub-module: desc_sync_fifo, a show-ahead synchronous FIFO with width DESC_WIDTH+PORT_IW+1 and depth FIFO_DEPTH, with full, empty and usedw.
- Round-robin arbiter and output FSM live in the top module.

## Test plan
- Single port: port 2 (port_type=1) presents 57'h1_2345 at cycle 0.
  - Response: ack[2] in cycle 1, to_host=1 with data 57'h1_2345 and inport=2 in cycle 2, held until i_descriptor_ack.
- All 4 ports present continuously, downstream acks immediately.
  - Response: grant order 0,1,2,3,0…; no port acked in consecutive cycles; accept pulses match acks.
- Downstream never acks, 4 ports stream.
  - Response: FIFO fills to usedw=8 plus 1 entry in the output register; further acks stop; sources keep wr high; releasing downstream drains all 9 in accept order.
- Port 1 is network, port 3 is terminal, both active.
  - Response: port 1 entries raise only to_network, port 3 entries only to_host; flipping port_type after accept does not change a queued entry's class.
- Assert reset_n=0 for one cycle mid-stream with FIFO at 5 entries and FSM in OUT_WAIT.
  - Response: all outputs 0 immediately; usedw=0 after release; next grant goes to port 0.
